// File: rtl/addr_ram_pkg.sv
// Shared types and constants for the layer-step to database-window lookup.
package addr_ram_pkg;

  localparam int STEP_W = 7;
  localparam int ADDR_W = 15;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PIX  = 2'd1,
    DW   = 2'd2,
    PW   = 2'd3
  } step_class_e;

  localparam logic [STEP_W-1:0] PIX_STEP_0 = 7'd1;
  localparam logic [STEP_W-1:0] PIX_STEP_1 = 7'd2;

  // DW steps run every 4 from 3 to 31, then resume at 37 after the PW 33/35 pair
  localparam logic [STEP_W-1:0] DW_LO_FIRST = 7'd3;
  localparam logic [STEP_W-1:0] DW_LO_LAST  = 7'd31;
  localparam logic [STEP_W-1:0] DW_HI_FIRST = 7'd37;
  localparam logic [STEP_W-1:0] DW_HI_LAST  = 7'd49;

  localparam logic [STEP_W-1:0] PW_LO_FIRST = 7'd5;
  localparam logic [STEP_W-1:0] PW_LO_LAST  = 7'd33;
  localparam logic [STEP_W-1:0] PW_HI_FIRST = 7'd35;
  localparam logic [STEP_W-1:0] PW_HI_LAST  = 7'd51;

  localparam logic [IDX_W-1:0] SPLIT_LAYER = 4'd8;

endpackage

// File: rtl/addr_step_decode.sv
// Combinational step classifier: class, layer index, and the number of
// opposite-kind weight blocks stored ahead of this one.
module addr_step_decode
  import addr_ram_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  output step_class_e       cls,
  output logic [IDX_W-1:0]  layer,
  output logic [IDX_W-1:0]  opp
);

  logic [STEP_W-1:0] dw_lo_off, dw_hi_off, pw_lo_off, pw_hi_off;

  assign dw_lo_off = step - DW_LO_FIRST;
  assign dw_hi_off = step - DW_HI_FIRST;
  assign pw_lo_off = step - PW_LO_FIRST;
  assign pw_hi_off = step - PW_HI_FIRST;

  always_comb begin
    cls   = IDLE;
    layer = '0;
    opp   = '0;
    if (step == PIX_STEP_0) begin
      cls = PIX;
    end else if (step == PIX_STEP_1) begin
      cls   = PIX;
      layer = 4'd1;
    end else if (step >= DW_LO_FIRST && step <= DW_LO_LAST && dw_lo_off[1:0] == 2'b00) begin
      cls   = DW;
      layer = IDX_W'(dw_lo_off >> 2);
      opp   = layer;
    end else if (step >= DW_HI_FIRST && step <= DW_HI_LAST && dw_hi_off[1:0] == 2'b00) begin
      cls   = DW;
      layer = IDX_W'(dw_hi_off >> 2) + SPLIT_LAYER;
      opp   = layer + 4'd1;
    end else if (step >= PW_LO_FIRST && step <= PW_LO_LAST && pw_lo_off[1:0] == 2'b00) begin
      cls   = PW;
      layer = IDX_W'(pw_lo_off >> 2);
      opp   = layer + 4'd1;
    end else if (step >= PW_HI_FIRST && step <= PW_HI_LAST && pw_hi_off[1:0] == 2'b00) begin
      cls   = PW;
      layer = IDX_W'(pw_hi_off >> 2) + SPLIT_LAYER;
      opp   = layer;
    end
  end

endmodule

// File: rtl/addr_ram_map.sv
// Registered step -> {firstaddr, lastaddr, read strobe} lookup for the memory loader.
// Optional ADDRRAM_OVF_EN adds an addr_ovf flag for windows ending past the address space.
module addr_ram_map
  import addr_ram_pkg::*;
#(
  parameter int unsigned picture_size          = 1024,
  parameter int unsigned convolution_size_1by1 = 64,
  parameter int unsigned convolution_size_3by3 = 288
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STEP_W-1:0] step,
  output logic              re_RAM_p,
  output logic              re_RAM_w,
  output logic [ADDR_W-1:0] firstaddr,
  output logic [ADDR_W-1:0] lastaddr
`ifdef ADDRRAM_OVF_EN
  ,
  output logic              addr_ovf
`endif
);

  localparam logic [31:0] PIC_BASE = 32'(2 * picture_size);
  localparam logic [31:0] PIC_SZ   = 32'(picture_size);
  localparam logic [31:0] C1_SZ    = 32'(convolution_size_1by1);
  localparam logic [31:0] C3_SZ    = 32'(convolution_size_3by3);

  step_class_e      cls;
  logic [IDX_W-1:0] layer, opp;
  logic [31:0]      first_full, size_full, last_full;
  logic             active;

  addr_step_decode u_decode (
    .step  (step),
    .cls   (cls),
    .layer (layer),
    .opp   (opp)
  );

  // Window arithmetic is done 32 bits wide so overflow past ADDR_W stays visible
  always_comb begin
    first_full = '0;
    size_full  = '0;
    active     = 1'b1;
    case (cls)
      PIX: begin
        first_full = (layer == '0) ? 32'd0 : PIC_SZ;
        size_full  = PIC_SZ;
      end
      DW: begin
        first_full = PIC_BASE + 32'(layer) * C3_SZ + 32'(opp) * C1_SZ;
        size_full  = C3_SZ;
      end
      PW: begin
        first_full = PIC_BASE + 32'(opp) * C3_SZ + 32'(layer) * C1_SZ;
        size_full  = C1_SZ;
      end
      default: active = 1'b0;
    endcase
    last_full = active ? (first_full + size_full - 32'd1) : 32'd0;
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_RAM_p  <= 1'b0;
      re_RAM_w  <= 1'b0;
      firstaddr <= '0;
      lastaddr  <= '0;
    end else begin
      re_RAM_p  <= (cls == PIX);
      re_RAM_w  <= (cls == DW) || (cls == PW);
      firstaddr <= first_full[ADDR_W-1:0];
      lastaddr  <= last_full[ADDR_W-1:0];
    end
  end

  logic unused_first_hi;
  assign unused_first_hi = ^first_full[31:ADDR_W];

`ifdef ADDRRAM_OVF_EN
  logic ovf_next;
  assign ovf_next = |last_full[31:ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_ovf <= 1'b0;
    else        addr_ovf <= ovf_next;
  end

  always @(posedge clk) begin
    if (rst_n && ovf_next && !addr_ovf)
      $error("addr_ram_map: window for step %0d ends at %0d, beyond the address space", step, last_full);
  end
`else
  logic unused_last_hi;
  assign unused_last_hi = ^last_full[31:ADDR_W];
`endif

endmodule

// File: tb/tb_addr_ram_map.sv
// Self-checking bench for addr_ram_map: directed table, corner sequences,
// and random steps against a cumulative memory-map model.
module tb_addr_ram_map;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  step;
  logic        re_RAM_p, re_RAM_w;
  logic [14:0] firstaddr, lastaddr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef ADDRRAM_OVF_EN
  logic        addr_ovf;
  logic [6:0]  step_b;
  logic        p_b, w_b, ovf_b;
  logic [14:0] f_b, l_b;
`endif

  addr_ram_map dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (step),
    .re_RAM_p  (re_RAM_p),
    .re_RAM_w  (re_RAM_w),
    .firstaddr (firstaddr),
    .lastaddr  (lastaddr)
`ifdef ADDRRAM_OVF_EN
    ,
    .addr_ovf  (addr_ovf)
`endif
  );

`ifdef ADDRRAM_OVF_EN
  addr_ram_map #(.picture_size(16384)) dut_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (step_b),
    .re_RAM_p  (p_b),
    .re_RAM_w  (w_b),
    .firstaddr (f_b),
    .lastaddr  (l_b),
    .addr_ovf  (ovf_b)
  );
`endif

  // Reference model: weight blocks sit after both pictures in ascending step order
  int dw_list[12] = '{3, 7, 11, 15, 19, 23, 27, 31, 37, 41, 45, 49};
  int pw_list[13] = '{5, 9, 13, 17, 21, 25, 29, 33, 35, 39, 43, 47, 51};
  bit m_p[128], m_w[128];
  int m_first[128], m_last[128];

  task automatic build_model();
    int addr;
    int sz;
    addr = 2 * 1024;
    for (int s = 0; s < 128; s++) begin
      m_p[s] = 0; m_w[s] = 0; m_first[s] = 0; m_last[s] = 0;
      sz = 0;
      foreach (dw_list[i]) if (dw_list[i] == s) sz = 288;
      foreach (pw_list[i]) if (pw_list[i] == s) sz = 64;
      if (s == 1 || s == 2) begin
        m_p[s] = 1;
        m_first[s] = (s - 1) * 1024;
        m_last[s] = m_first[s] + 1023;
      end else if (sz != 0) begin
        m_w[s] = 1;
        m_first[s] = addr;
        m_last[s] = addr + sz - 1;
        addr += sz;
      end
    end
  endtask

  task automatic check(input string name, input logic p, input logic w,
                       input logic [14:0] f, input logic [14:0] l);
    n_checks++;
    if ({re_RAM_p, re_RAM_w, firstaddr, lastaddr} !== {p, w, f, l}) begin
      n_fail++;
      $display("FAIL %s: got p=%0b w=%0b first=%0d last=%0d, want p=%0b w=%0b first=%0d last=%0d",
               name, re_RAM_p, re_RAM_w, firstaddr, lastaddr, p, w, f, l);
    end
  endtask

  task automatic check_model(input string name, input int s);
    check(name, m_p[s], m_w[s], 15'(m_first[s]), 15'(m_last[s]));
  endtask

  task automatic apply(input logic [6:0] s);
    @(negedge clk);
    step = s;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [6:0]  step;
    logic        p;
    logic        w;
    logic [14:0] first;
    logic [14:0] last;
  } vec_t;

  vec_t tbl[14];

  initial begin
    build_model();
    tbl = '{
      '{7'd1,  1'b1, 1'b0, 15'd0,    15'd1023},
      '{7'd3,  1'b0, 1'b1, 15'd2048, 15'd2335},
      '{7'd5,  1'b0, 1'b1, 15'd2336, 15'd2399},
      '{7'd33, 1'b0, 1'b1, 15'd4800, 15'd4863},
      '{7'd35, 1'b0, 1'b1, 15'd4864, 15'd4927},
      '{7'd37, 1'b0, 1'b1, 15'd4928, 15'd5215},
      '{7'd51, 1'b0, 1'b1, 15'd6272, 15'd6335},
      '{7'd49, 1'b0, 1'b1, 15'd5984, 15'd6271},
      '{7'd4,  1'b0, 1'b0, 15'd0,    15'd0},
      '{7'd34, 1'b0, 1'b0, 15'd0,    15'd0},
      '{7'd0,  1'b0, 1'b0, 15'd0,    15'd0},
      '{7'd60, 1'b0, 1'b0, 15'd0,    15'd0},
      '{7'd52, 1'b0, 1'b0, 15'd0,    15'd0},
      '{7'd2,  1'b1, 1'b0, 15'd1024, 15'd2047}
    };

    rst_n = 1'b0;
    step  = 7'd2;
`ifdef ADDRRAM_OVF_EN
    step_b = 7'd0;
`endif
    #1;
    check("reset_state", 1'b0, 1'b0, 15'd0, 15'd0);
    @(posedge clk); #1;
    check("reset_held_over_edge", 1'b0, 1'b0, 15'd0, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_edge_after_reset", 1'b1, 1'b0, 15'd1024, 15'd2047);

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].step);
      check($sformatf("table_step_%0d", tbl[i].step), tbl[i].p, tbl[i].w, tbl[i].first, tbl[i].last);
    end

    // One-cycle lag: the new step must not show before the next rising edge
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      step = (i % 2 == 0) ? 7'd4 : 7'd2;
      #1;
      if (i % 2 == 0) check("lag_before_edge", 1'b1, 1'b0, 15'd1024, 15'd2047);
      else            check("lag_before_edge", 1'b0, 1'b0, 15'd0, 15'd0);
      @(posedge clk); #1;
      if (i % 2 == 0) check("lag_after_edge", 1'b0, 1'b0, 15'd0, 15'd0);
      else            check("lag_after_edge", 1'b1, 1'b0, 15'd1024, 15'd2047);
    end

    // Asynchronous reset mid-cycle, then release with a weight step present
    apply(7'd51);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_midcycle", 1'b0, 1'b0, 15'd0, 15'd0);
    step = 7'd9;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_model("release_loads_step_9", 9);

    for (int i = 0; i < 300; i++) begin
      int s;
      s = (i % 3 == 0) ? int'($urandom_range(0, 55)) : int'($urandom_range(0, 127));
      apply(7'(s));
      check_model($sformatf("random_step_%0d", s), s);
      n_checks++;
      if (re_RAM_p && re_RAM_w) begin
        n_fail++;
        $display("FAIL strobes_exclusive: got p=1 w=1, want at most one high");
      end
`ifdef ADDRRAM_OVF_EN
      n_checks++;
      if (addr_ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL ovf_default: got %0b want 0", addr_ovf);
      end
`endif
    end

`ifdef ADDRRAM_OVF_EN
    @(negedge clk); step_b = 7'd2;
    @(posedge clk); #1;
    n_checks++;
    if ({p_b, ovf_b, l_b} !== {1'b1, 1'b0, 15'd32767}) begin
      n_fail++;
      $display("FAIL ovf_big_step2: got p=%0b ovf=%0b last=%0d want p=1 ovf=0 last=32767", p_b, ovf_b, l_b);
    end
    @(negedge clk); step_b = 7'd3;
    @(posedge clk); #1;
    n_checks++;
    if ({w_b, ovf_b, f_b, l_b} !== {1'b1, 1'b1, 15'd0, 15'd287}) begin
      n_fail++;
      $display("FAIL ovf_big_step3: got w=%0b ovf=%0b first=%0d last=%0d want w=1 ovf=1 first=0 last=287",
               w_b, ovf_b, f_b, l_b);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
